lcd_status_reader: RTL and testbench
====================================

LCD_STATUS_READER -- requirements
Module: lcd_status_reader

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 3, iCLK cycles with RS/RW stable before EN rises.
REQ-002 SHALL have parameter EN_HIGH_CYC, default 24, iCLK cycles EN held high.
REQ-003 SHALL have parameter HOLD_CYC, default 2, iCLK cycles RS/RW held after EN falls.
REQ-004 SHALL have parameter MAX_POLLS, default 4095, busy-poll read limit before timeout.
REQ-005 SHALL have ports, clock and reset first:
 iCLK  in  1  system clock (50 MHz);
 iRST_N  in  1  asynchronous active-low reset;
 iREQ  in  1  start a read, sampled in IDLE only;
 iRS  in  1  0 = busy flag/address read, 1 = data RAM read;
 iPOLL  in  1  with iRS=0, repeat reads until BF=0;
 LCD_DATA_IN  in  8  LCD data bus, read side;
 LCD_EN  out  1  LCD enable strobe;
 LCD_RW  out  1  1 = read cycle;
 LCD_RS  out  1  register select;
 oBUS_OWN  out  1  reader owns LCD bus, writer driver SHALL tri-state;
 oBUSY  out  1  transaction in progress;
 oDONE  out  1  one-cycle completion pulse;
 oDATA  out  8  last sampled byte;
 oBF  out  1  oDATA[7] when iRS was 0;
 oADDR  out  7  oDATA[6:0] when iRS was 0;
 oTIMEOUT  out  1  poll limit reached, valid with oDONE.

Function
REQ-006 SHALL implement states IDLE, SETUP, EN_HI, HOLD, DONE.
REQ-007 IDLE with iREQ=1 SHALL latch iRS/iPOLL (iPOLL forced 0 when iRS=1), clear poll count, go to SETUP next cycle.
REQ-008 SETUP SHALL drive RW=1, RS=latched, EN=0 for SETUP_CYC cycles, then go to EN_HI.
REQ-009 EN_HI SHALL drive EN=1 for EN_HIGH_CYC cycles; LCD_DATA_IN SHALL be registered into oDATA on the last EN_HI cycle only.
REQ-010 HOLD SHALL drive EN=0, RW=1, RS unchanged for HOLD_CYC cycles.
REQ-011 After HOLD: if polling, sampled BF=1 and poll count < MAX_POLLS, SHALL increment count and re-enter SETUP; else go to DONE.
REQ-012 Poll count reaching MAX_POLLS with BF still 1 SHALL set oTIMEOUT=1 for that transaction.
REQ-013 DONE SHALL pulse oDONE for exactly one cycle, return to IDLE, RW=0.
REQ-014 Single-read latency, iREQ sample to oDONE, SHALL be 1+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+1 cycles (31 at defaults).
REQ-015 oBUSY and oBUS_OWN SHALL be 1 in SETUP, EN_HI, HOLD; oBUSY also in DONE.
REQ-016 iREQ outside IDLE SHALL be ignored, not queued; iRS/iPOLL changes mid-transaction SHALL be ignored.
REQ-017 oDATA/oBF/oADDR/oTIMEOUT SHALL hold until the next transaction's sample; oTIMEOUT SHALL clear at next IDLE start.
REQ-018 Phase counters SHALL treat parameter value 0 as 1 cycle.

Reset
REQ-019 iRST_N low SHALL asynchronously force IDLE and EN=0, RW=0, RS=0, oBUS_OWN=0, oBUSY=0, oDONE=0, oTIMEOUT=0, oDATA=0x00, poll count 0.
REQ-020 Reset during EN_HI SHALL drop EN immediately; no oDONE SHALL follow.
REQ-021 Reset release SHALL be synchronised inside the block; first iREQ accepted on second iCLK edge after release.

Structure
REQ-022 State enum and timing defaults SHALL live in shared package lcd_pkg, used also by the LCD write controller.
REQ-023 One sub-module lcd_phase_timer (loadable down-counter, zero flag) SHALL time SETUP/EN_HI/HOLD.

Verification
REQ-024 Single busy read, bus=0x2A: iREQ, iRS=0 -> oDONE at cycle 31, oBF=0, oADDR=0x2A, EN high exactly 24 cycles.
REQ-025 Data read, bus=0xC5: iRS=1, iPOLL=1 -> one read only, oDATA=0xC5, RS=1 throughout SETUP..HOLD.
REQ-026 Poll: bus=0x80 for 3 reads then 0x05 -> 4 read cycles, oBF=0, oADDR=0x05, oTIMEOUT=0.
REQ-027 MAX_POLLS=2, bus stuck 0x80 -> 3 reads, oDONE with oTIMEOUT=1, oBF=1.
REQ-028 iRST_N low mid-EN_HI -> EN/RW/oBUS_OWN 0 same cycle, no oDONE; iREQ pulses during a read produce no extra transaction.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD controller package: sequencer state encoding, default bus timing
// and the phase-timer load helper. Used by both the status reader and the
// LCD write controller, so timing defaults stay consistent between them.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_e;

  // Default bus timing in clock cycles at 50 MHz.
  localparam int unsigned LCD_SETUP_CYC_DEF   = 3;
  localparam int unsigned LCD_EN_HIGH_CYC_DEF = 24;
  localparam int unsigned LCD_HOLD_CYC_DEF    = 2;
  localparam int unsigned LCD_MAX_POLLS_DEF   = 4095;

  localparam int unsigned LCD_TMR_W = 16;
  typedef logic [LCD_TMR_W-1:0] lcd_tmr_t;

  // A phase of N cycles loads N-1 into the down-counter; N=0 behaves as N=1.
  function automatic lcd_tmr_t lcd_phase_load(input int unsigned cyc);
    if (cyc == 0) return '0;
    return lcd_tmr_t'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter used to time the LCD bus phases. The zero flag
// marks the last cycle of the current phase.
module lcd_phase_timer
  import lcd_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     load_i,
  input  lcd_tmr_t load_val_i,
  output logic     zero_o
);

  lcd_tmr_t cnt_q;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - lcd_tmr_t'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// LCD status/data reader. Runs one or more HD44780-style read cycles and
// returns the sampled byte; in poll mode it repeats busy-flag reads until
// BF clears or the poll limit is hit.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | bus released, waiting for iREQ
// ST_SETUP | RW=1, RS valid, EN low (address setup)
// ST_EN_HI | EN high; bus sampled on the last cycle
// ST_HOLD  | EN low, RS/RW held; decide re-poll or finish
// ST_DONE  | one-cycle oDONE pulse, bus released
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = LCD_SETUP_CYC_DEF,
  parameter int unsigned EN_HIGH_CYC = LCD_EN_HIGH_CYC_DEF,
  parameter int unsigned HOLD_CYC    = LCD_HOLD_CYC_DEF,
  parameter int unsigned MAX_POLLS   = LCD_MAX_POLLS_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic       iPOLL,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       oBUS_OWN,
  output logic       oBUSY,
  output logic       oDONE,
  output logic [7:0] oDATA,
  output logic       oBF,
  output logic [6:0] oADDR,
  output logic       oTIMEOUT
);

  localparam lcd_tmr_t SETUP_LD = lcd_phase_load(SETUP_CYC);
  localparam lcd_tmr_t EN_LD    = lcd_phase_load(EN_HIGH_CYC);
  localparam lcd_tmr_t HOLD_LD  = lcd_phase_load(HOLD_CYC);

  // Poll counter is one bit wider than needed so MAX_POLLS itself fits.
  localparam int unsigned PCW = $clog2(MAX_POLLS + 1) + 1;
  localparam logic [PCW-1:0] MAX_POLLS_L = PCW'(MAX_POLLS);

  lcd_state_e     state_q;
  logic           run_q;
  logic           rs_q;
  logic           poll_q;
  logic [PCW-1:0] poll_cnt_q;
  logic           en_q;
  logic           rw_q;
  logic           rs_out_q;
  logic           own_q;
  logic           busy_q;
  logic           done_q;
  logic           timeout_q;
  logic [7:0]     data_q;
  logic           bf_q;
  logic [6:0]     addr_q;

  logic     start;
  logic     repoll;
  logic     tmr_zero;
  logic     tmr_load;
  lcd_tmr_t tmr_load_val;

  // Reset release qualifier: the block leaves reset on the first edge after
  // iRST_N rises, so the earliest accepted iREQ is on the second edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign start  = (state_q == ST_IDLE) && run_q && iREQ;
  assign repoll = poll_q && data_q[7] && (poll_cnt_q < MAX_POLLS_L);

  // Timer reload on every phase entry, mirroring the FSM transitions below.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tmr_load     = 1'b1;
          tmr_load_val = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = EN_LD;
        end
      end
      ST_EN_HI: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero && repoll) begin
          tmr_load     = 1'b1;
          tmr_load_val = SETUP_LD;
        end
      end
      default: begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
      end
    endcase
  end

  lcd_phase_timer u_phase_timer (
    .clk_i      (iCLK),
    .rst_ni     (iRST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  // Read sequencer with registered bus and status outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      poll_cnt_q <= '0;
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      rs_out_q   <= 1'b0;
      own_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= 8'h00;
      bf_q       <= 1'b0;
      addr_q     <= 7'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Data RAM reads never poll; only the busy flag is meaningful.
            rs_q       <= iRS;
            poll_q     <= iPOLL & ~iRS;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
            rw_q       <= 1'b1;
            rs_out_q   <= iRS;
            own_q      <= 1'b1;
            busy_q     <= 1'b1;
            en_q       <= 1'b0;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            en_q    <= 1'b1;
            state_q <= ST_EN_HI;
          end
        end
        ST_EN_HI: begin
          if (tmr_zero) begin
            en_q    <= 1'b0;
            data_q  <= LCD_DATA_IN;
            if (!rs_q) begin
              bf_q   <= LCD_DATA_IN[7];
              addr_q <= LCD_DATA_IN[6:0];
            end
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            if (repoll) begin
              poll_cnt_q <= poll_cnt_q + PCW'(1);
              state_q    <= ST_SETUP;
            end else begin
              // Still busy while polling here means the limit was reached.
              timeout_q <= poll_q & data_q[7];
              rw_q      <= 1'b0;
              rs_out_q  <= 1'b0;
              own_q     <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          en_q     <= 1'b0;
          rw_q     <= 1'b0;
          rs_out_q <= 1'b0;
          own_q    <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign LCD_EN   = en_q;
  assign LCD_RW   = rw_q;
  assign LCD_RS   = rs_out_q;
  assign oBUS_OWN = own_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;
  assign oDATA    = data_q;
  assign oBF      = bf_q;
  assign oADDR    = addr_q;
  assign oTIMEOUT = timeout_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Bench for lcd_status_reader: unit 0 uses default timing, unit 1 uses
// zero/short phase parameters and MAX_POLLS=2. Expected results come from a
// transaction-level model of read count, final byte, latency and timeout.
module tb_lcd_status_reader;

  localparam int unsigned S1 = 0, E1 = 2, H1 = 0, MP1 = 2;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       req   [2];
  logic       rs    [2];
  logic       poll  [2];
  logic [7:0] bus   [2];
  logic       en    [2];
  logic       rw    [2];
  logic       rso   [2];
  logic       own   [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] data  [2];
  logic       bf    [2];
  logic [6:0] addr  [2];
  logic       to    [2];

  int s_eff [2];
  int e_eff [2];
  int h_eff [2];
  int mp    [2];

  logic       exp_bf   [2];
  logic [6:0] exp_addr [2];

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  lcd_status_reader u_dut0 (
    .iCLK(clk), .iRST_N(rst_n[0]), .iREQ(req[0]), .iRS(rs[0]), .iPOLL(poll[0]),
    .LCD_DATA_IN(bus[0]), .LCD_EN(en[0]), .LCD_RW(rw[0]), .LCD_RS(rso[0]),
    .oBUS_OWN(own[0]), .oBUSY(busy[0]), .oDONE(done[0]), .oDATA(data[0]),
    .oBF(bf[0]), .oADDR(addr[0]), .oTIMEOUT(to[0])
  );

  lcd_status_reader #(
    .SETUP_CYC(S1), .EN_HIGH_CYC(E1), .HOLD_CYC(H1), .MAX_POLLS(MP1)
  ) u_dut1 (
    .iCLK(clk), .iRST_N(rst_n[1]), .iREQ(req[1]), .iRS(rs[1]), .iPOLL(poll[1]),
    .LCD_DATA_IN(bus[1]), .LCD_EN(en[1]), .LCD_RW(rw[1]), .LCD_RS(rso[1]),
    .oBUS_OWN(own[1]), .oBUSY(busy[1]), .oDONE(done[1]), .oDATA(data[1]),
    .oBF(bf[1]), .oADDR(addr[1]), .oTIMEOUT(to[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] vat(input logic [7:0] v[$], input int i);
    if (i >= v.size()) return v[v.size()-1];
    return v[i];
  endfunction

  // Number of bus reads: one, unless busy-polling, where reads continue while
  // BF=1 and fewer than maxp re-polls have been made.
  function automatic int model_reads(input logic r, input logic p, input int maxp,
                                     input logic [7:0] v[$]);
    int n;
    logic [7:0] b;
    n = 1;
    if (r || !p) return 1;
    forever begin
      b = vat(v, n - 1);
      if (!b[7] || (n - 1) >= maxp) break;
      n++;
    end
    return n;
  endfunction

  // One transaction on unit u; bus shows v[k] only on the last EN-high cycle
  // of read k and inverted/random data otherwise.
  task automatic run_txn(input int u, input string tag, input logic r, input logic p,
                         input logic [7:0] v[$], input bit spam);
    int exp_reads, exp_lat, cyc, reads, run, bad_en, bad_bus, lat, bc;
    logic [7:0] last;
    logic exp_to;
    bit done_seen;
    exp_reads = model_reads(r, p, mp[u], v);
    last      = vat(v, exp_reads - 1);
    exp_to    = !r && p && last[7];
    // Request cycle counts as cycle 1; oDONE appears in the cycle after the last HOLD.
    exp_lat   = 1 + exp_reads * (s_eff[u] + e_eff[u] + h_eff[u]) + 1;
    rs[u] = r; poll[u] = p; req[u] = 1'b1; bus[u] = 8'($urandom);
    cyc = 1; reads = 0; run = 0; bad_en = 0; bad_bus = 0; lat = 0; bc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < exp_lat + 40) begin
      @(posedge clk); #1;
      cyc++;
      req[u]  = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      rs[u]   = 1'($urandom_range(0, 1));
      poll[u] = 1'($urandom_range(0, 1));
      if (en[u]) begin
        if (run == 0) reads++;
        run++;
        bus[u] = (run == e_eff[u]) ? vat(v, reads - 1) : ~vat(v, reads - 1);
      end else begin
        if (run != 0 && run != e_eff[u]) bad_en++;
        run = 0;
        bus[u] = 8'($urandom);
      end
      if (own[u] && (rso[u] !== r || rw[u] !== 1'b1 || busy[u] !== 1'b1)) bad_bus++;
      if (done[u]) begin
        done_seen = 1'b1;
        lat = cyc;
        req[u] = 1'b0;
      end
    end
    req[u] = 1'b0;
    if (!r) begin
      exp_bf[u]   = last[7];
      exp_addr[u] = last[6:0];
    end
    check({tag, ".done_cycle"}, lat, exp_lat);
    check({tag, ".reads"}, reads, exp_reads);
    check({tag, ".en_width_errs"}, bad_en, 0);
    check({tag, ".rs_rw_errs"}, bad_bus, 0);
    check({tag, ".data"}, data[u], last);
    check({tag, ".bf"}, bf[u], exp_bf[u]);
    check({tag, ".addr"}, addr[u], exp_addr[u]);
    check({tag, ".timeout"}, to[u], exp_to);
    check({tag, ".busy_in_done"}, busy[u], 1);
    check({tag, ".own_in_done"}, own[u], 0);
    check({tag, ".rw_in_done"}, rw[u], 0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done[u], 0);
    check({tag, ".busy_after"}, busy[u], 0);
    check({tag, ".timeout_hold"}, to[u], exp_to);
    if (spam) begin
      repeat (4) begin
        @(posedge clk); #1;
        if (busy[u]) bc++;
      end
      check({tag, ".no_queued_req"}, bc, 0);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    s_eff[0] = 3; e_eff[0] = 24; h_eff[0] = 2; mp[0] = 4095;
    s_eff[1] = 1; e_eff[1] = 2;  h_eff[1] = 1; mp[1] = MP1;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; req[u] = 1'b0; rs[u] = 1'b0; poll[u] = 1'b0; bus[u] = 8'h00;
      exp_bf[u] = 1'b0; exp_addr[u] = 7'h00;
    end

    // Reset values on both units.
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst%0d.en", u), en[u], 0);
      check($sformatf("rst%0d.rw", u), rw[u], 0);
      check($sformatf("rst%0d.rs", u), rso[u], 0);
      check($sformatf("rst%0d.own", u), own[u], 0);
      check($sformatf("rst%0d.busy", u), busy[u], 0);
      check($sformatf("rst%0d.done", u), done[u], 0);
      check($sformatf("rst%0d.timeout", u), to[u], 0);
      check($sformatf("rst%0d.data", u), data[u], 8'h00);
    end

    // Release with iREQ already high: accepted on the second edge, not the first.
    req[0] = 1'b1; rs[0] = 1'b1; bus[0] = 8'h11;
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;
    check("sync.busy_edge1", busy[0], 0);
    @(posedge clk); #1;
    check("sync.busy_edge2", busy[0], 1);
    req[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("sync.done_seen", done[0], 1);
    check("sync.data", data[0], 8'h11);
    check("sync.bf_untouched", bf[0], 0);
    @(posedge clk); #1;

    // Directed transactions, default timing.
    q = '{8'h2A};
    run_txn(0, "busy_read", 1'b0, 1'b0, q, 1'b0);
    q = '{8'hC5, 8'h00};
    run_txn(0, "data_read", 1'b1, 1'b1, q, 1'b0);
    q = '{8'h80, 8'h80, 8'h80, 8'h05};
    run_txn(0, "poll4", 1'b0, 1'b1, q, 1'b0);
    q = '{8'h3C};
    run_txn(0, "req_spam", 1'b0, 1'b0, q, 1'b1);

    // Short timing, MAX_POLLS=2.
    q = '{8'h80};
    run_txn(1, "poll_timeout", 1'b0, 1'b1, q, 1'b0);
    q = '{8'h80, 8'h80, 8'h05};
    run_txn(1, "poll_ok_at_limit", 1'b0, 1'b1, q, 1'b0);
    q = '{8'hB7};
    run_txn(1, "busy_no_poll", 1'b0, 1'b0, q, 1'b0);

    // Randomized transactions on both units.
    for (int i = 0; i < 16; i++) begin
      int u, len;
      logic r, p;
      logic [7:0] tmp;
      bit sp;
      u   = i % 2;
      r   = 1'($urandom_range(0, 1));
      p   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      sp  = ($urandom_range(0, 3) == 0);
      q.delete();
      for (int j = 0; j < len; j++) q.push_back(8'($urandom));
      if (u == 0) begin
        tmp = q[len-1];
        tmp[7] = 1'b0;
        q[len-1] = tmp;
      end
      run_txn(u, $sformatf("rnd%0d", i), r, p, q, sp);
    end

    // Reset asserted mid EN-high: bus released at once, no completion.
    req[0] = 1'b1; rs[0] = 1'b0; poll[0] = 1'b0; bus[0] = 8'h55;
    @(posedge clk); #1;
    req[0] = 1'b0;
    n = 0;
    while (!en[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst.en_reached", en[0], 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    check("midrst.en", en[0], 0);
    check("midrst.rw", rw[0], 0);
    check("midrst.own", own[0], 0);
    check("midrst.busy", busy[0], 0);
    check("midrst.data", data[0], 8'h00);
    exp_bf[0] = 1'b0; exp_addr[0] = 7'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done[0]) n++;
    end
    check("midrst.no_done", n, 0);

    // Unit 0 still works after the mid-transaction reset.
    q = '{8'h80, 8'h12};
    run_txn(0, "after_rst", 1'b0, 1'b1, q, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
